// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit and instruction memory.
//   imem_req_valid  fetch request valid
//   imem_req_addr   word-aligned fetch address
//   imem_req_ready  memory accepts the request this cycle
//   imem_rsp_valid  response word valid (one-cycle pulse)
//   imem_rsp_data   returned instruction word
// master: the fetch unit; slave: the instruction memory.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding a single-cycle core. Owns the PC, keeps at most one
// instruction-memory request outstanding, and buffers the returned word in a one-entry
// output register.
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   imem            instruction-memory bus (master side)
//   redirect_valid  core requests a PC change (one-cycle pulse)
//   redirect_pc     new PC; bits [1:0] are ignored
//   stall           core cannot consume the buffered instruction this cycle
//   pc_out          PC of the buffered instruction (feeds the core's pcounter)
//   instr_out       buffered instruction, NOP_INSTR when not valid
//   instr_valid     output buffer holds a live instruction
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic            instr_valid
);

  typedef enum logic [1:0] {StReq, StWait, StFull} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            squash_q, squash_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            handshake;

  // Redirect targets are forced word aligned; the low bits are dropped on purpose.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // req_valid_q is only ever high in StReq, and stays low for the cycle after reset release.
  assign handshake = req_valid_q & imem.imem_req_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    squash_d   = squash_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      unique case (state_q)
        StReq: begin
          // An accepted request is still in flight; its response must be dropped.
          if (handshake) begin
            state_d  = StWait;
            squash_d = 1'b1;
          end
        end
        StWait: begin
          if (imem.imem_rsp_valid) begin
            state_d  = StReq;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (handshake) state_d = StWait;
        end
        StWait: begin
          if (imem.imem_rsp_valid) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = StReq;
            end else begin
              instr_d    = imem.imem_rsp_data;
              pc_d       = fetch_pc_q;
              valid_d    = 1'b1;
              fetch_pc_d = fetch_pc_q + XLEN'(4);
              state_d    = StFull;
            end
          end
        end
        StFull: begin
          if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end

    req_valid_d = (state_d == StReq);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StReq;
      fetch_pc_q  <= RESET_PC;
      squash_q    <= 1'b0;
      req_valid_q <= 1'b0;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      squash_q    <= squash_d;
      req_valid_q <= req_valid_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_req_addr  = fetch_pc_q;
  assign pc_out              = pc_q;
  assign instr_out           = instr_q;
  assign instr_valid         = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit. Each row drives one cycle of inputs at the falling
// edge and checks the registered outputs just after, before the next rising edge.
module tb_fetch_unit;

  localparam logic [31:0] N = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        stray;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] epc;
    logic [31:0] ei;
    logic        eiv;
  } vec_t;

  vec_t vecs[$];

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        stray_ok;
  logic        outstanding;
  int          checks;
  int          fails;

  fetch_unit_if #(.XLEN(32)) imem ();

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (imem),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: a response with no accepted request outstanding is a violation,
  // except where a row deliberately injects a stray response.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= 1'b0;
    end else begin
      if (imem.imem_rsp_valid && !outstanding && !stray_ok) begin
        checks++;
        fails++;
        $display("FAIL protocol: rsp_valid=1 with no outstanding request at %0t", $time);
      end
      if (imem.imem_rsp_valid) outstanding <= 1'b0;
      if (imem.imem_req_valid && imem.imem_req_ready) outstanding <= 1'b1;
    end
  end

  function automatic void add(input logic [31:0] rst, rdy, rv, rd, redir, rpc, stl, stray,
                              input logic [31:0] ev, ea, epc, ei, eiv);
    vec_t v;
    v.rst = rst[0]; v.rdy = rdy[0]; v.rv = rv[0]; v.rd = rd; v.redir = redir[0];
    v.rpc = rpc; v.stl = stl[0]; v.stray = stray[0];
    v.ev = ev[0]; v.ea = ea; v.epc = epc; v.ei = ei; v.eiv = eiv[0];
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
    end
  endtask

  initial begin
    reset          = 1'b0;
    stray_ok       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    checks = 0;
    fails  = 0;

    //  rst rdy rv rd  redir rpc  stl stray | ev ea  epc  ei  eiv
    // Streaming fetch: words A, B, C at 0x0, 0x4, 0x8.
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, N, 0);
    add(1, 0, 1, 32'hA, 0, 0, 0, 0,   0, 0, 0, N, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 4, 0, 32'hA, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 4, 0, N, 0);
    add(1, 0, 1, 32'hB, 0, 0, 0, 0,   0, 4, 0, N, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 8, 4, 32'hB, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 8, 4, N, 0);
    add(1, 0, 1, 32'hC, 0, 0, 0, 0,   0, 8, 4, N, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 32'hC, 8, 32'hC, 1);
    // Stall holds the buffer for five cycles, then the next request issues.
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, N, 0);
    add(1, 0, 1, 32'hA, 0, 0, 0, 0,   0, 0, 0, N, 0);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 0, 1, 0,   0, 4, 0, 32'hA, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 4, 0, 32'hA, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0,   1, 4, 0, N, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0,   1, 4, 0, N, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0,   1, 4, 0, N, 0);
    // Redirect to 0x103 while waiting; late response 0xDEAD is squashed.
    add(1, 0, 0, 0, 1, 32'h103, 0, 0,   0, 4, 0, N, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 32'h100, 0, N, 0);
    add(1, 0, 1, 32'hDEAD, 0, 0, 0, 0,   0, 32'h100, 0, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 32'h100, 0, N, 0);
    add(1, 0, 1, 32'h1111, 0, 0, 0, 0,   0, 32'h100, 0, N, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 32'h104, 32'h100, 32'h1111, 1);
    // Redirect to 0x200 coincident with a response.
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 32'h104, 32'h100, N, 0);
    add(1, 0, 1, 32'h2222, 1, 32'h200, 0, 0,   0, 32'h104, 32'h100, N, 0);
    // Redirect to 0x40 coincident with a request handshake.
    add(1, 1, 0, 0, 1, 32'h40, 0, 0,   1, 32'h200, 32'h100, N, 0);
    add(1, 0, 1, 32'h3333, 0, 0, 0, 0,   0, 32'h40, 32'h100, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 32'h40, 32'h100, N, 0);
    add(1, 0, 1, 32'h4444, 0, 0, 0, 0,   0, 32'h40, 32'h100, N, 0);
    // Redirect in FULL under stall drops the buffer; redirect in REQ without handshake.
    add(1, 0, 0, 0, 1, 32'h1000, 1, 0,   0, 32'h44, 32'h40, 32'h4444, 1);
    add(1, 0, 0, 0, 1, 32'h2002, 0, 0,   1, 32'h1000, 32'h40, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 32'h2000, 32'h40, N, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 32'h2000, 32'h40, N, 0);
    // Reset while waiting; stray responses around release are ignored.
    add(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, N, 0);
    add(0, 0, 1, 32'hBAD, 0, 0, 0, 0,   0, 0, 0, N, 0);
    add(1, 0, 1, 32'hBAD, 0, 0, 0, 1,   0, 0, 0, N, 0);
    add(1, 0, 1, 32'hBAD, 0, 0, 0, 1,   1, 0, 0, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, N, 0);
    add(1, 0, 1, 32'h5555, 0, 0, 0, 0,   0, 0, 0, N, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 4, 0, 32'h5555, 1);
    // PC wraps from 0xFFFF_FFFC to 0.
    add(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0,   1, 4, 0, N, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   1, 32'hFFFF_FFFC, 0, N, 0);
    add(1, 0, 1, 32'h6666, 0, 0, 0, 0,   0, 32'hFFFF_FFFC, 0, N, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'hFFFF_FFFC, 32'h6666, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 32'hFFFF_FFFC, N, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset               = vecs[i].rst;
      imem.imem_req_ready = vecs[i].rdy;
      imem.imem_rsp_valid = vecs[i].rv;
      imem.imem_rsp_data  = vecs[i].rd;
      redirect_valid      = vecs[i].redir;
      redirect_pc         = vecs[i].rpc;
      stall               = vecs[i].stl;
      stray_ok            = vecs[i].stray;
      #1;
      chk("req_valid", i, {31'b0, imem.imem_req_valid}, {31'b0, vecs[i].ev});
      chk("req_addr", i, imem.imem_req_addr, vecs[i].ea);
      chk("pc_out", i, pc_out, vecs[i].epc);
      chk("instr_out", i, instr_out, vecs[i].ei);
      chk("instr_valid", i, {31'b0, instr_valid}, {31'b0, vecs[i].eiv});
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
